// File: rtl/if_pkg.sv
// Shared types for the instruction fetch unit: opcodes, FSM states
// and J/B immediate decoders (sign-extended to 32 bits).
package if_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ST_FETCH      = 2'd0,
    ST_WAIT_IC    = 2'd1,
    ST_DRAIN      = 2'd2,
    ST_STALL_JALR = 2'd3
  } if_state_e;

  function automatic logic signed [31:0] imm_j(
    input logic [31:0] inst
  );
    return {{11{inst[31]}}, inst[31], inst[19:12],
            inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic signed [31:0] imm_b(
    input logic [31:0] inst
  );
    return {{19{inst[31]}}, inst[31], inst[7],
            inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, inst, pred} entries.
// Ports: clk/rst, push/pop/clear (clear wins), din/dout, full/empty/count.
module fetch_queue #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clear) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_d = rd_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch unit: one outstanding ICache request, FQ_DEPTH-entry queue to
// decode, PC redirect on jal/taken branch/jalr/flush, branch feedback.
module inst_fetch_queue
  import if_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           FQ_DEPTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  output logic                  IFIC_en,
  output logic [ADDR_WIDTH-1:0] IFIC_addr,
  input  logic                  ICIF_en,
  input  logic [31:0]           ICIF_data,
  output logic                  IFPD_predict_en,
  output logic [ADDR_WIDTH-1:0] IFPD_pc,
  input  logic                  PDIF_predict_result,
  output logic                  IFPD_feedback_en,
  output logic                  IFPD_branch_result,
  output logic [ADDR_WIDTH-1:0] IFPD_feedback_pc,
  input  logic                  DCIF_ask_IF,
  output logic                  IFDC_en,
  output logic [ADDR_WIDTH-1:0] IFDC_pc,
  output logic [31:0]           IFDC_inst,
  output logic                  IFDC_predict_result,
  input  logic                  RoBIF_jalr_en,
  input  logic                  RoBIF_branch_en,
  input  logic                  RoBIF_pre_judge,
  input  logic                  RoBIF_branch_result,
  input  logic [ADDR_WIDTH-1:0] RoBIF_branch_pc,
  input  logic [ADDR_WIDTH-1:0] RoBIF_next_pc
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned EW = AW + 33;

  if_state_e state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          fb_en_q, fb_en_d;
  logic          fb_res_q, fb_res_d;
  logic [AW-1:0] fb_pc_q, fb_pc_d;

  logic [6:0]        opc;
  logic              is_jal, is_br, is_jalr;
  logic              flush, resp, pred_bit;
  logic signed [31:0] j_imm, b_imm;
  logic [AW-1:0]     pc_seq, pc_jal, pc_br, resp_pc;

  logic          fq_push, fq_pop, fq_clear;
  logic          fq_full, fq_empty;
  logic [CW-1:0] fq_count;
  logic [EW-1:0] fq_din, fq_dout;

  assign opc     = ICIF_data[6:0];
  assign is_jal  = (opc == OPC_JAL);
  assign is_br   = (opc == OPC_BRANCH);
  assign is_jalr = (opc == OPC_JALR);

  assign flush    = RoBIF_branch_en && !RoBIF_pre_judge;
  assign resp     = (state_q == ST_WAIT_IC) && ICIF_en;
  assign pred_bit = is_br && PDIF_predict_result;

  assign j_imm  = imm_j(ICIF_data);
  assign b_imm  = imm_b(ICIF_data);
  assign pc_seq = pc_q + AW'(4);
  assign pc_jal = pc_q + AW'(j_imm);
  assign pc_br  = pc_q + AW'(b_imm);

  always_comb begin
    resp_pc = pc_seq;
    unique case (1'b1)
      is_jal:  resp_pc = pc_jal;
      is_br:   resp_pc = pred_bit ? pc_br : pc_seq;
      is_jalr: resp_pc = pc_q;
      default: resp_pc = pc_seq;
    endcase
  end

  // Queue side effects only take place on enabled cycles.
  assign fq_push  = Sys_rdy && resp && !flush;
  assign fq_pop   = Sys_rdy && !fq_empty && DCIF_ask_IF;
  assign fq_clear = Sys_rdy && flush;
  assign fq_din   = {pc_q, ICIF_data, pred_bit};

  fetch_queue #(
    .WIDTH (EW),
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk   (Sys_clk),
    .rst   (Sys_rst),
    .push  (fq_push),
    .pop   (fq_pop),
    .clear (fq_clear),
    .din   (fq_din),
    .dout  (fq_dout),
    .full  (fq_full),
    .empty (fq_empty),
    .count (fq_count)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    fb_en_d  = RoBIF_branch_en;
    fb_res_d = fb_res_q;
    fb_pc_d  = fb_pc_q;
    if (RoBIF_branch_en) begin
      fb_res_d = RoBIF_branch_result;
      fb_pc_d  = RoBIF_branch_pc;
    end
    unique case (state_q)
      ST_FETCH: begin
        if (!fq_full) state_d = ST_WAIT_IC;
      end
      ST_WAIT_IC: begin
        if (ICIF_en) begin
          pc_d    = resp_pc;
          state_d = is_jalr ? ST_STALL_JALR : ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (ICIF_en) state_d = ST_FETCH;
      end
      ST_STALL_JALR: begin
        if (RoBIF_jalr_en) begin
          pc_d    = RoBIF_next_pc;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
    // A request still in flight must be drained so its data is dropped.
    if (flush) begin
      pc_d = RoBIF_next_pc;
      if ((state_q == ST_WAIT_IC || state_q == ST_DRAIN)
          && !ICIF_en) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_FETCH;
      end
    end
  end

  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      fb_en_q  <= 1'b0;
      fb_res_q <= 1'b0;
      fb_pc_q  <= '0;
    end else if (Sys_rdy) begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      fb_en_q  <= fb_en_d;
      fb_res_q <= fb_res_d;
      fb_pc_q  <= fb_pc_d;
    end
  end

  assign IFIC_en = ((state_q == ST_FETCH)
                    && (fq_count < CW'(FQ_DEPTH)))
                   || (state_q == ST_WAIT_IC)
                   || (state_q == ST_DRAIN);
  assign IFIC_addr = pc_q;
  assign IFPD_pc   = pc_q;

  assign IFPD_predict_en    = resp && is_br;
  assign IFPD_feedback_en   = fb_en_q;
  assign IFPD_branch_result = fb_res_q;
  assign IFPD_feedback_pc   = fb_pc_q;

  assign IFDC_en             = !fq_empty;
  assign IFDC_pc             = fq_dout[EW-1 -: AW];
  assign IFDC_inst           = fq_dout[32:1];
  assign IFDC_predict_result = fq_dout[0];

endmodule
